// File: rtl/quad_decoder_4bit.sv
// Quadrature decoder: synchronizes encoder phases A/B and turns each Gray-code
// transition into an up/down step of a wrapping 4-bit position count.
module quad_decoder_4bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       quad_a,
    input  logic       quad_b,
    input  logic       clear,
    output logic [3:0] count,
    output logic       up_down,
    output logic       step,
    output logic       err
);

    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       init_cnt_q, init_cnt_d;
    logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
    logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
    logic [1:0]             prev_q, prev_d;
    logic [3:0]             count_q, count_d;
    logic                   up_down_q, up_down_d;
    logic                   step_q, step_d;
    logic                   err_q, err_d;

    logic [1:0] cur;
    logic [1:0] pos_cur, pos_prev, delta;

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_d     = prev_q;
        count_d    = count_q;
        up_down_d  = up_down_q;
        step_d     = 1'b0;
        err_d      = err_q;

        a_sync_d = {a_sync_q[SYNC_STAGES-2:0], quad_a};
        b_sync_d = {b_sync_q[SYNC_STAGES-2:0], quad_b};
        cur      = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

        // Gray code to position along the up sequence 00,01,11,10
        pos_cur  = {cur[1], cur[1] ^ cur[0]};
        pos_prev = {prev_q[1], prev_q[1] ^ prev_q[0]};
        delta    = pos_cur - pos_prev;

        unique case (state_q)
            S_INIT: begin
                if (init_cnt_q == CNT_W'(SYNC_STAGES)) begin
                    prev_d  = cur;
                    state_d = S_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                prev_d = cur;
                unique case (delta)
                    2'd1: begin
                        count_d   = count_q + 4'd1;
                        up_down_d = 1'b1;
                        step_d    = 1'b1;
                    end
                    2'd3: begin
                        count_d   = count_q - 4'd1;
                        up_down_d = 1'b0;
                        step_d    = 1'b1;
                    end
                    2'd2: begin
                        err_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        endcase

        // Clear wins over a same-cycle step or error
        if (clear) begin
            count_d   = 4'd0;
            err_d     = 1'b0;
            step_d    = 1'b0;
            up_down_d = up_down_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            a_sync_q   <= '0;
            b_sync_q   <= '0;
            prev_q     <= 2'b00;
            count_q    <= 4'd0;
            up_down_q  <= 1'b1;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            a_sync_q   <= a_sync_d;
            b_sync_q   <= b_sync_d;
            prev_q     <= prev_d;
            count_q    <= count_d;
            up_down_q  <= up_down_d;
            step_q     <= step_d;
            err_q      <= err_d;
        end
    end

    assign count   = count_q;
    assign up_down = up_down_q;
    assign step    = step_q;
    assign err     = err_q;

endmodule

// File: tb/tb_quad_decoder_4bit.sv
// Directed bench for quad_decoder_4bit: walks the encoder through legal,
// reverse, illegal, clear and mid-operation reset scenarios.
module tb_quad_decoder_4bit;

    logic       clk;
    logic       reset;
    logic [1:0] ab;
    logic       clear;
    logic [3:0] count;
    logic       up_down;
    logic       step;
    logic       err;

    int checks = 0;
    int errors = 0;
    int step_cnt = 0;

    logic [3:0] exp_cnt;
    logic       exp_ud;
    logic       exp_err;
    int         base;

    quad_decoder_4bit #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .quad_a  (ab[1]),
        .quad_b  (ab[0]),
        .clear   (clear),
        .count   (count),
        .up_down (up_down),
        .step    (step),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count step pulses away from the active edge
    always @(negedge clk) if (step === 1'b1) step_cnt++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag);
        check({tag, " count"}, 32'(count), 32'(exp_cnt));
        check({tag, " up_down"}, 32'(up_down), 32'(exp_ud));
        check({tag, " err"}, 32'(err), 32'(exp_err));
    endtask

    // Drive one A/B change; dir: +1 up, -1 down, 0 illegal. Four clocks per transition.
    task automatic xition(input logic [1:0] nxt, input int dir, input string tag);
        ab = nxt;
        tick();
        tick();
        check({tag, " early step"}, 32'(step), 32'd0);
        check({tag, " early count"}, 32'(count), 32'(exp_cnt));
        tick();
        if (dir == 1) begin
            exp_cnt = exp_cnt + 4'd1;
            exp_ud  = 1'b1;
        end else if (dir == -1) begin
            exp_cnt = exp_cnt - 4'd1;
            exp_ud  = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
        check({tag, " step"}, 32'(step), (dir != 0) ? 32'd1 : 32'd0);
        check_outs(tag);
        tick();
        check({tag, " step low"}, 32'(step), 32'd0);
    endtask

    initial begin
        reset   = 1'b0;
        clear   = 1'b0;
        ab      = 2'b11;
        exp_cnt = 4'd0;
        exp_ud  = 1'b1;
        exp_err = 1'b0;

        // Reset held with A/B = 11, then released
        repeat (3) tick();
        check("rst step", 32'(step), 32'd0);
        check_outs("rst");
        reset = 1'b1;
        repeat (10) tick();
        check("hold11 no steps", 32'(step_cnt), 32'd0);
        check_outs("hold11");

        // Restart from A/B = 00
        reset = 1'b0;
        ab    = 2'b00;
        tick();
        reset = 1'b1;
        repeat (8) tick();
        check_outs("restart");

        // Five full up cycles: 20 steps, passes 15->0, ends at 4
        base = step_cnt;
        for (int i = 0; i < 5; i++) begin
            xition(2'b01, 1, "up");
            xition(2'b11, 1, "up");
            xition(2'b10, 1, "up");
            xition(2'b00, 1, "up");
        end
        check("up pulses", 32'(step_cnt - base), 32'd20);
        check("up final count", 32'(count), 32'd4);

        // Six reverse steps: 3,2,1,0,15,14
        xition(2'b10, -1, "dn");
        xition(2'b11, -1, "dn");
        xition(2'b01, -1, "dn");
        xition(2'b00, -1, "dn");
        xition(2'b10, -1, "dn");
        xition(2'b11, -1, "dn");
        check("dn final count", 32'(count), 32'd14);

        // Illegal 01->10 jump, then a legal up step keeps err sticky
        xition(2'b01, -1, "pre_ill");
        xition(2'b10, 0, "illegal");
        xition(2'b00, 1, "post_ill");
        check("err sticky", 32'(err), 32'd1);

        // Clear coinciding with a decoded forward step
        ab = 2'b01;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear   = 1'b0;
        exp_cnt = 4'd0;
        exp_err = 1'b0;
        check("clr step", 32'(step), 32'd0);
        check_outs("clr");
        tick();
        check("clr after step", 32'(step), 32'd0);
        xition(2'b11, 1, "post_clr");
        check("post_clr count", 32'(count), 32'd1);

        // Short reset during an in-flight up step
        base = step_cnt;
        ab   = 2'b10;
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_cnt = 4'd0;
        exp_ud  = 1'b1;
        exp_err = 1'b0;
        check("midrst step", 32'(step), 32'd0);
        check_outs("midrst");
        #3;
        reset = 1'b1;
        repeat (8) tick();
        check("midrst no pending", 32'(step_cnt - base), 32'd0);
        check_outs("midrst init");
        xition(2'b00, 1, "after_rst");
        check("after_rst count", 32'(count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/quad_decoder_4bit.md
# quad_decoder_4bit

Quadrature decoder that turns a two-phase encoder signal pair (A/B) into the up/down stepping that drives a 4-bit counter. The block synchronizes the asynchronous A/B inputs and decodes each Gray-code transition as one step up or one step down. It maintains a wrapping 4-bit position count, outputs the direction of the last step, and flags illegal transitions. It sits between an external encoder and the counter/display logic, acting as the source side of the `up_down`/count interface.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages in each A/B synchronizer; legal values ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `quad_a`  in  1  encoder phase A; asynchronous to `clk`.
- `quad_b`  in  1  encoder phase B; asynchronous to `clk`.
- `clear`  in  1  synchronous clear of `count` and `err`; active-high.
- `count`  out  4  position count; wraps modulo 16.
- `up_down`  out  1  direction of the last valid step: 1 = up, 0 = down.
- `step`  out  1  one-cycle pulse on each valid step.
- `err`  out  1  sticky flag: an illegal transition was seen.

## Operation
- Synchronizer: A and B each pass through `SYNC_STAGES` flops. The synchronized pair `cur = {a_s, b_s}` is compared with the registered previous pair `prev`.
- Up sequence: 00→01→11→10→00. Down sequence is the reverse: 00→10→11→01→00.
- Decision, made every cycle in RUN:
  - `cur == prev`: no action; `step` = 0.
  - Forward transition: `count` ← `count`+1, `up_down` ← 1, `step` ← 1.
  - Reverse transition: `count` ← `count`−1, `up_down` ← 0, `step` ← 1.
  - Both bits changed (00↔11, 01↔10): `err` ← 1. `count` and `up_down` are unchanged and `step` = 0.
  - `prev` ← `cur` in every case.
- Wrap-around: 15 + up → 0; 0 + down → 15. There is no saturation and no carry output.
- State machine:
  - INIT: entered on reset. Counts `SYNC_STAGES` cycles while the synchronizer fills, then loads `prev` ← `cur` without making a decision, then moves to RUN.
  - RUN: decodes every cycle. It leaves RUN only on reset.
  - This prevents a spurious step or error when the inputs are non-zero at reset release.
- `clear` (RUN or INIT):
  - `count` ← 0 and `err` ← 0; `step` = 0 that cycle.
  - A step decoded in the same cycle is discarded, but `prev` still updates.
  - `up_down` is unchanged.
  - `clear` has priority over both step and error.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronously). The state machine returns to INIT. No pending step survives.

## Timing
- Reset values:
  - `count` = 0000, `up_down` = 1, `step` = 0, `err` = 0.
  - Synchronizer flops and `prev` = 00; state = INIT.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- First decision: RUN begins at the (`SYNC_STAGES`+1)th rising edge after reset deasserts.
- Latency: an A/B change sampled at edge k updates `count`/`step`/`up_down` at edge k+`SYNC_STAGES`. With the default, that is 2 edges after sampling.
- `step` is high for exactly one cycle per valid transition. Consecutive steps on back-to-back cycles give back-to-back pulses.
- Maximum input rate: one A/B transition per `clk` cycle. Faster inputs show up as illegal transitions (`err`).
- `err` stays set until `clear` or reset.

## Test plan
- Reset with A/B = 11 held, then release; hold for 10 cycles → `count` = 0, `step` never pulses, `err` = 0, `up_down` = 1.
- Drive the up sequence 00→01→11→10→00 for 5 full cycles, with transitions 4 clocks apart → 20 `step` pulses. `count` passes 15→0 and ends at 4; `up_down` = 1.
- From `count` = 4, drive 6 reverse transitions → `count` goes 3,2,1,0,15,14 and `up_down` = 0 after the first of them. Each new value appears exactly 2 edges after the input change is sampled.
- Jump A/B 01→10 directly → `err` = 1, `count` unchanged, `step` = 0. A following legal up transition increments `count`, and `err` stays 1.
- Assert `clear` in the same cycle a forward step is decoded → `count` = 0, `err` = 0, `step` = 0. The next legal forward transition gives `count` = 1.
- Assert `reset` = 0 for half a cycle in the middle of an up sequence, then release → outputs return to reset values immediately. The bench then waits out INIT; the next legal transition counts from 0.
